reg_file_sb: RTL and testbench

Architectural register file with an integrated issue scoreboard: the read/consume end of the writeback interface. It sits in the decode stage. It accepts `reg_wr_data`/`reg_dest`/`reg_wr` from writeback and serves two operand read ports. It tracks pending destination writes for issued instructions and raises `stall` when a source or destination hazard would otherwise produce stale data.

---
 rtl/reg_file_sb.sv | 153 +++++++++++++++
 tb/tb_reg_file_sb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with integrated issue scoreboard for the decode stage.
// Optional macro RF_BYPASS_EN enables writeback-to-read bypass and early hazard release.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        rd_addr1,
  input  logic              rd_en1,
  input  logic [3:0]        rd_addr2,
  input  logic              rd_en2,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [3:0]        issue_dest,
  input  logic              flush,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic [3:0]        reg_dest,
  input  logic              reg_wr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              stall,
  output logic              sb_err
);

  localparam int         NREG       = 16;
  localparam logic [1:0] MAX_PEND_C = 2'(MAX_PEND);

  logic [DATA_W-1:0] regs_r     [NREG];
  logic [1:0]        pend_r     [NREG];
  logic [1:0]        pend_nxt_s [NREG];
  logic              sb_err_r;
  logic              underflow_s;
  logic [NREG-1:0]   retire_s;
  logic [NREG-1:0]   busy_s;
  logic              src1_haz_s;
  logic              src2_haz_s;
  logic              dest_full_s;
  logic              stall_s;
  logic              issue_s;

  // Operand read with R0 hardwired to zero and optional writeback forwarding.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] addr);
    logic [DATA_W-1:0] val;
    if (addr == 4'd0) begin
      val = {DATA_W{1'b0}};
    end else begin
      val = regs_r[addr];
`ifdef RF_BYPASS_EN
      if (reg_wr && (reg_dest == addr)) begin
        val = reg_wr_data;
      end else begin
        val = regs_r[addr];
      end
`endif
    end
    return val;
  endfunction

  // Per-register retire decode; R0 never retires.
  always_comb begin
    retire_s = {NREG{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      retire_s[r] = reg_wr & (reg_dest == 4'(r));
    end
  end

  // Busy flags; with bypass the last outstanding write releases readers in its WB cycle.
  always_comb begin
    busy_s = {NREG{1'b0}};
    for (int r = 1; r < NREG; r++) begin
`ifdef RF_BYPASS_EN
      busy_s[r] = (pend_r[r] != 2'd0) & ~((pend_r[r] == 2'd1) & retire_s[r]);
`else
      busy_s[r] = (pend_r[r] != 2'd0);
`endif
    end
  end

  // Hazard detection and the resulting issue event.
  always_comb begin
    src1_haz_s  = rd_en1 & (rd_addr1 != 4'd0) & busy_s[rd_addr1];
    src2_haz_s  = rd_en2 & (rd_addr2 != 4'd0) & busy_s[rd_addr2];
    dest_full_s = issue_wr & (issue_dest != 4'd0) &
                  (pend_r[issue_dest] == MAX_PEND_C) & ~retire_s[issue_dest];
    stall_s     = issue_valid & (src1_haz_s | src2_haz_s | dest_full_s);
    issue_s     = issue_valid & issue_wr & ~stall_s & (issue_dest != 4'd0) & ~flush;
  end

  // Next pending counts; an issue and retire on the same register cancel out.
  always_comb begin
    underflow_s   = 1'b0;
    pend_nxt_s[0] = 2'd0;
    for (int r = 1; r < NREG; r++) begin
      pend_nxt_s[r] = pend_r[r];
      if (issue_s && (issue_dest == 4'(r)) && retire_s[r]) begin
        pend_nxt_s[r] = pend_r[r];
      end else if (issue_s && (issue_dest == 4'(r))) begin
        pend_nxt_s[r] = pend_r[r] + 2'd1;
      end else if (retire_s[r]) begin
        if (pend_r[r] == 2'd0) begin
          underflow_s = 1'b1;
        end else begin
          pend_nxt_s[r] = pend_r[r] - 2'd1;
        end
      end else begin
        pend_nxt_s[r] = pend_r[r];
      end
      if (flush) begin
        pend_nxt_s[r] = 2'd0;
      end else begin
        pend_nxt_s[r] = pend_nxt_s[r];
      end
    end
  end

  // Architectural storage; writes to R0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
      end
    end else if (reg_wr && (reg_dest != 4'd0)) begin
      regs_r[reg_dest] <= reg_wr_data;
    end
  end

  // Scoreboard counters and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        pend_r[r] <= 2'd0;
      end
      sb_err_r <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_r[r] <= pend_nxt_s[r];
      end
      if (underflow_s) begin
        sb_err_r <= 1'b1;
      end
    end
  end

  // Output drive.
  always_comb begin
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
    stall    = stall_s;
    sb_err   = sb_err_r;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic
// compared against a register/count reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rd_addr1, rd_addr2, issue_dest, reg_dest;
  logic        rd_en1, rd_en2, issue_valid, issue_wr, flush, reg_wr;
  logic [31:0] reg_wr_data;
  logic [31:0] rd_data1, rd_data2;
  logic        stall, sb_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem  [16];
  int          m_pend [16];
  bit          m_err;
  bit          e_stall;

  reg_file_sb #(.DATA_W(32), .MAX_PEND(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_en1(rd_en1), .rd_addr2(rd_addr2), .rd_en2(rd_en2),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
    .flush(flush), .reg_wr_data(reg_wr_data), .reg_dest(reg_dest), .reg_wr(reg_wr),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_mem[r]  = 32'd0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic bit bsy(input logic [3:0] a);
    if (a == 4'd0) return 1'b0;
    if (m_pend[a] == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (m_pend[a] == 1 && reg_wr && reg_dest == a) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit model_stall();
    bit full;
    full = issue_wr && issue_dest != 4'd0 && m_pend[issue_dest] == 3 &&
           !(reg_wr && reg_dest == issue_dest);
    return issue_valid && ((rd_en1 && bsy(rd_addr1)) || (rd_en2 && bsy(rd_addr2)) || full);
  endfunction

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    if (a == 4'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (reg_wr && reg_dest == a) return reg_wr_data;
`endif
    return m_mem[a];
  endfunction

  task automatic model_update();
    bit iss, ret;
    iss = issue_valid && issue_wr && !e_stall && issue_dest != 4'd0 && !flush;
    ret = reg_wr && reg_dest != 4'd0;
    if (ret) m_mem[reg_dest] = reg_wr_data;
    if (!(iss && ret && issue_dest == reg_dest)) begin
      if (iss) m_pend[issue_dest]++;
      if (ret) begin
        if (m_pend[reg_dest] == 0) m_err = 1'b1;
        else m_pend[reg_dest]--;
      end
    end
    if (flush) for (int r = 0; r < 16; r++) m_pend[r] = 0;
  endtask

  task automatic idle();
    rd_addr1 = 4'd0; rd_en1 = 1'b0; rd_addr2 = 4'd0; rd_en2 = 1'b0;
    issue_valid = 1'b0; issue_wr = 1'b0; issue_dest = 4'd0; flush = 1'b0;
    reg_wr = 1'b0; reg_dest = 4'd0; reg_wr_data = 32'd0;
  endtask

  task automatic step_eval();
    #4;
    e_stall = model_stall();
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("rd_data1", rd_data1, model_rd(rd_addr1));
    chk("rd_data2", rd_data2, model_rd(rd_addr2));
    chk("sb_err", {31'd0, sb_err}, {31'd0, m_err});
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    step_eval();
    step_clk();
  endtask

  task automatic do_issue(input logic [3:0] d);
    idle(); issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = d;
  endtask

  task automatic do_wb(input logic [3:0] d, input logic [31:0] v);
    reg_wr = 1'b1; reg_dest = d; reg_wr_data = v;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    rd_addr1 = 4'd5; rd_addr2 = 4'd9;
    step_eval();
    chk("rst_rd1", rd_data1, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    step_clk();

    // R5 write and read back
    do_issue(4'd5); step();
    idle(); do_wb(4'd5, 32'hDEADBEEF); step();
    idle(); issue_valid = 1'b1; rd_en1 = 1'b1; rd_addr1 = 4'd5;
    step_eval();
    chk("r5_read", rd_data1, 32'hDEADBEEF);
    chk("r5_stall", {31'd0, stall}, 32'd0);
    step_clk();

    // R3 dependency
    do_issue(4'd3); step();
    idle(); issue_valid = 1'b1; rd_en1 = 1'b1; rd_addr1 = 4'd3;
    step_eval(); chk("r3_wait", {31'd0, stall}, 32'd1); step_clk();
    do_wb(4'd3, 32'h1234);
    step_eval();
`ifdef RF_BYPASS_EN
    chk("r3_byp_stall", {31'd0, stall}, 32'd0);
    chk("r3_byp_data", rd_data1, 32'h1234);
`else
    chk("r3_wb_stall", {31'd0, stall}, 32'd1);
`endif
    step_clk();
    reg_wr = 1'b0;
    step_eval();
    chk("r3_after_stall", {31'd0, stall}, 32'd0);
    chk("r3_after_data", rd_data1, 32'h1234);
    step_clk();

    // R0 is never written or scoreboarded
    do_issue(4'd0); do_wb(4'd0, 32'hFFFFFFFF); rd_en1 = 1'b1; rd_addr1 = 4'd0;
    step_eval(); chk("r0_rd", rd_data1, 32'd0); chk("r0_stall", {31'd0, stall}, 32'd0); step_clk();
    idle(); issue_valid = 1'b1; rd_en2 = 1'b1; rd_addr2 = 4'd0;
    step_eval(); chk("r0_rd2", rd_data2, 32'd0); chk("r0_err", {31'd0, sb_err}, 32'd0); step_clk();

    // R7 saturation
    repeat (3) begin do_issue(4'd7); step(); end
    do_issue(4'd7);
    step_eval(); chk("r7_full", {31'd0, stall}, 32'd1); step_clk();
    do_wb(4'd7, 32'h77);
    step_eval(); chk("r7_full_ret", {31'd0, stall}, 32'd0); step_clk();
    reg_wr = 1'b0;
    step_eval(); chk("r7_still_full", {31'd0, stall}, 32'd1); step_clk();
    repeat (3) begin idle(); do_wb(4'd7, $urandom); step(); end

    // R2 net-zero, then R9 underflow
    do_issue(4'd2); step();
    do_issue(4'd2); do_wb(4'd2, 32'h22);
    step_eval(); chk("r2_net0_stall", {31'd0, stall}, 32'd0); step_clk();
    idle(); step_eval(); chk("r2_no_err", {31'd0, sb_err}, 32'd0); step_clk();
    do_wb(4'd9, 32'h99); step();
    idle(); step_eval(); chk("r9_err", {31'd0, sb_err}, 32'd1); step_clk();
    do_wb(4'd2, 32'h2222); step();
    idle(); step_eval(); chk("err_sticky", {31'd0, sb_err}, 32'd1); step_clk();

    // flush
    do_issue(4'd4); step();
    do_issue(4'd6); step();
    idle(); flush = 1'b1; step();
    idle(); issue_valid = 1'b1; rd_en1 = 1'b1; rd_addr1 = 4'd4; rd_en2 = 1'b1; rd_addr2 = 4'd6;
    step_eval(); chk("flush_stall", {31'd0, stall}, 32'd0); step_clk();

    // reset mid-operation
    do_issue(4'd8); step();
    rst_n = 1'b0;
    #2;
    model_reset();
    idle(); issue_valid = 1'b1; rd_en1 = 1'b1; rd_addr1 = 4'd8; rd_addr2 = 4'd5;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_err", {31'd0, sb_err}, 32'd0);
    chk("mid_rst_rd2", rd_data2, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // random traffic
    for (int n = 0; n < 800; n++) begin
      int start;
      idle();
      rd_addr1 = 4'($urandom_range(0, 15)); rd_en1 = 1'($urandom);
      rd_addr2 = 4'($urandom_range(0, 15)); rd_en2 = 1'($urandom);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr = 1'($urandom);
      issue_dest = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 59) == 0);
      reg_wr_data = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        reg_wr = 1'b1; reg_dest = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 9) < 5) begin
        start = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
          if (!reg_wr && m_pend[(start + k) % 16] > 0) begin
            reg_wr = 1'b1; reg_dest = 4'((start + k) % 16);
          end
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
